// File: rtl/sel_sequencer.sv
// Select-code sequencer: issues a run of up/down/gray/fixed select values
// to a downstream decoder under ready/valid handshake, then pulses done.
module sel_sequencer #(
   parameter logic [1:0] FIXED_SEL = 2'd2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [1:0] mode,
   input  logic [3:0] len,
   input  logic       ready,
   output logic [1:0] sel,
   output logic       sel_valid,
   output logic       busy,
   output logic       done,
   output logic [4:0] issued
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      DONE  = 2'd2
   } state_t;

   localparam logic [1:0] MODE_UP    = 2'b00;
   localparam logic [1:0] MODE_DOWN  = 2'b01;
   localparam logic [1:0] MODE_GRAY  = 2'b10;

   state_t     state_q, state_d;
   logic [1:0] sel_q, sel_d;
   logic [1:0] mode_q, mode_d;
   logic [3:0] len_q, len_d;
   logic [4:0] issued_q, issued_d;

   logic [4:0] eff_len;
   logic       xfer;
   logic       last_xfer;

   function automatic logic [1:0] first_sel(input logic [1:0] m);
      case (m)
         MODE_UP:   first_sel = 2'd0;
         MODE_DOWN: first_sel = 2'd3;
         MODE_GRAY: first_sel = 2'd0;
         default:   first_sel = FIXED_SEL;
      endcase
   endfunction

   function automatic logic [1:0] next_sel(input logic [1:0] m, input logic [1:0] s);
      case (m)
         MODE_UP:   next_sel = s + 2'd1;
         MODE_DOWN: next_sel = s - 2'd1;
         MODE_GRAY: begin
            // gray walk 0 -> 1 -> 3 -> 2 -> 0
            case (s)
               2'd0:    next_sel = 2'd1;
               2'd1:    next_sel = 2'd3;
               2'd3:    next_sel = 2'd2;
               default: next_sel = 2'd0;
            endcase
         end
         default:   next_sel = FIXED_SEL;
      endcase
   endfunction

   assign eff_len   = (len_q == 4'd0) ? 5'd16 : {1'b0, len_q};
   assign xfer      = (state_q == ISSUE) && ready;
   assign last_xfer = xfer && ((issued_q + 5'd1) == eff_len);

   always_comb begin
      state_d  = state_q;
      sel_d    = sel_q;
      mode_d   = mode_q;
      len_d    = len_q;
      issued_d = issued_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               mode_d   = mode;
               len_d    = len;
               issued_d = 5'd0;
               sel_d    = first_sel(mode);
               state_d  = ISSUE;
            end
         end
         ISSUE: begin
            if (xfer) begin
               issued_d = issued_q + 5'd1;
               if (last_xfer) begin
                  state_d = DONE;
               end else begin
                  sel_d = next_sel(mode_q, sel_q);
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         sel_q    <= 2'd0;
         mode_q   <= 2'd0;
         len_q    <= 4'd0;
         issued_q <= 5'd0;
      end else begin
         state_q  <= state_d;
         sel_q    <= sel_d;
         mode_q   <= mode_d;
         len_q    <= len_d;
         issued_q <= issued_d;
      end
   end

   assign sel       = sel_q;
   assign sel_valid = (state_q == ISSUE);
   assign busy      = (state_q != IDLE);
   assign done      = (state_q == DONE);
   assign issued    = issued_q;

endmodule

// File: tb/tb_sel_sequencer.sv
// Directed bench for sel_sequencer: each run is stepped cycle by cycle and
// outputs are compared to hand-computed select sequences and counts.
module tb_sel_sequencer;

   logic       clk;
   logic       rst;
   logic       start;
   logic [1:0] mode;
   logic [3:0] len;
   logic       ready;
   logic [1:0] sel;
   logic       sel_valid;
   logic       busy;
   logic       done;
   logic [4:0] issued;

   int checks = 0;
   int errors = 0;

   sel_sequencer #(.FIXED_SEL(2'd2)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .mode      (mode),
      .len       (len),
      .ready     (ready),
      .sel       (sel),
      .sel_valid (sel_valid),
      .busy      (busy),
      .done      (done),
      .issued    (issued)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_out(input string tag, input int e_sel, input int e_vld,
                          input int e_busy, input int e_done, input int e_iss);
      chk({tag, ".sel"},    int'(sel),       e_sel);
      chk({tag, ".valid"},  int'(sel_valid), e_vld);
      chk({tag, ".busy"},   int'(busy),      e_busy);
      chk({tag, ".done"},   int'(done),      e_done);
      chk({tag, ".issued"}, int'(issued),    e_iss);
   endtask

   int up_seq   [5]  = '{0, 1, 2, 3, 0};
   int gray_seq [4]  = '{0, 1, 3, 2};
   int dn_rdy   [5]  = '{1, 0, 0, 1, 1};
   int dn_sel   [5]  = '{3, 2, 2, 2, 1};
   int dn_iss   [5]  = '{0, 1, 1, 1, 2};

   initial begin
      rst = 1'b1; start = 1'b0; mode = 2'b00; len = 4'd0; ready = 1'b0;
      tick();
      chk_out("reset", 0, 0, 0, 0, 0);
      rst = 1'b0;

      // up, len=5, ready held high
      start = 1'b1; mode = 2'b00; len = 4'd5; ready = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 5; i++) begin
         chk_out($sformatf("up%0d", i), up_seq[i], 1, 1, 0, i);
         tick();
      end
      chk_out("up_done", 0, 0, 1, 1, 5);
      tick();
      chk_out("up_idle", 0, 0, 0, 0, 5);

      // gray, len=0 means 16
      start = 1'b1; mode = 2'b10; len = 4'd0; ready = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 16; i++) begin
         chk($sformatf("gray%0d.sel", i), int'(sel), gray_seq[i % 4]);
         chk($sformatf("gray%0d.valid", i), int'(sel_valid), 1);
         tick();
      end
      chk_out("gray_done", 2, 0, 1, 1, 16);
      tick();

      // down, len=3, ready pattern with stalls
      start = 1'b1; mode = 2'b01; len = 4'd3; ready = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 5; i++) begin
         ready = dn_rdy[i][0];
         chk_out($sformatf("down%0d", i), dn_sel[i], 1, 1, 0, dn_iss[i]);
         tick();
      end
      chk_out("down_done", 1, 0, 1, 1, 3);
      tick();

      // fixed, len=2, start re-pulsed and mode/len changed mid-run
      start = 1'b1; mode = 2'b11; len = 4'd2; ready = 1'b1;
      tick();
      chk_out("fix0", 2, 1, 1, 0, 0);
      start = 1'b1; mode = 2'b00; len = 4'd7;
      tick();
      chk_out("fix1", 2, 1, 1, 0, 1);
      start = 1'b0;
      tick();
      chk_out("fix_done", 2, 0, 1, 1, 2);
      // start held through DONE is only taken once back in IDLE
      start = 1'b1; mode = 2'b00; len = 4'd4;
      tick();
      chk_out("fix_idle", 2, 0, 0, 0, 2);
      tick();
      start = 1'b0;
      chk_out("up4_s0", 0, 1, 1, 0, 0);
      tick();
      chk_out("up4_s1", 1, 1, 1, 0, 1);

      // reset during the second step aborts the run
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk_out("abort", 0, 0, 0, 0, 0);
      tick();
      chk_out("abort_nodone", 0, 0, 0, 0, 0);

      // start together with reset is dropped
      rst = 1'b1; start = 1'b1; mode = 2'b01; len = 4'd2;
      tick();
      chk_out("rst_start", 0, 0, 0, 0, 0);
      rst = 1'b0;
      tick();
      start = 1'b0;
      chk_out("start_after_rst", 3, 1, 1, 0, 0);
      tick();
      tick();
      chk_out("after_rst_done", 2, 0, 1, 1, 2);
      tick();
      chk_out("after_rst_idle", 2, 0, 0, 0, 2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/sel_sequencer.md
SEL_SEQUENCER -- requirements
Module: sel_sequencer

Interface
REQ-001 The block SHALL have parameter FIXED_SEL, default 2'd2, the select value issued in fixed mode.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates occur on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, reset; synchronous, active-high.
REQ-004 The block SHALL have port start, input, 1, a run request, sampled only in IDLE.
REQ-005 The block SHALL have port mode, input, 2, the sequence pattern: 00 up, 01 down, 10 gray, 11 fixed.
REQ-006 The block SHALL have port len, input, 4, the number of selects to issue per run; 0 means 16.
REQ-007 The block SHALL have port ready, input, 1, downstream acceptance of sel.
REQ-008 The block SHALL have port sel, output, 2, the select code fed to the downstream condition decoder.
REQ-009 The block SHALL have port sel_valid, output, 1, indicating sel holds a valid step.
REQ-010 The block SHALL have port busy, output, 1, high whenever the state is not IDLE.
REQ-011 The block SHALL have port done, output, 1, a one-cycle pulse marking the end of a run.
REQ-012 The block SHALL have port issued, output, 5, the count of accepted transfers in the current or last run.

Function
REQ-013 The block SHALL implement the states IDLE, ISSUE and DONE.
REQ-014 In IDLE with start=1, the block SHALL capture mode and len, clear issued to 0, load sel with the first value of the chosen pattern, and enter ISSUE on the next edge.
REQ-015 sel_valid SHALL be 1 exactly while in ISSUE, so start at cycle N gives sel_valid=1 at N+1.
REQ-016 A transfer SHALL occur on a cycle where sel_valid=1 and ready=1; issued then increments by 1.
REQ-017 While sel_valid=1 and ready=0, sel SHALL hold its value.
REQ-018 On a transfer that is not the last, sel SHALL advance to the next pattern value on the next edge.
REQ-019 Pattern sequences SHALL be: up 0,1,2,3,0,... (wraps 3->0); down 3,2,1,0,3,...; gray 0,1,3,2,0,...; fixed FIXED_SEL on every step.
REQ-020 On the transfer where issued+1 equals the effective length (len, or 16 if len=0), the block SHALL enter DONE.
REQ-021 In DONE, done=1, sel_valid=0 and busy=1 for exactly one cycle; the block SHALL then return to IDLE.
REQ-022 A last transfer at cycle M SHALL give done=1 at M+1, and a new start SHALL be accepted from M+2.
REQ-023 start, mode and len changes outside IDLE SHALL be ignored; the captured values govern the whole run.
REQ-024 In IDLE and DONE, sel SHALL hold its last value and issued SHALL hold its final count until the next accepted start.
REQ-025 With ready held at 1, the block SHALL issue one select per cycle with no bubbles.

Reset
REQ-026 On rst=1 at a rising edge, the block SHALL force state to IDLE, sel=0, sel_valid=0, busy=0, done=0 and issued=0, regardless of the current state.
REQ-027 rst SHALL take priority over start in the same cycle; start is not captured.
REQ-028 Reset asserted mid-run SHALL abort the run without a done pulse.

Verification
REQ-029 Up mode, len=5, ready=1 -> sel 0,1,2,3,0 on consecutive cycles, then done pulse, issued=5.
REQ-030 Gray mode, len=0, ready=1 -> 16 transfers repeating 0,1,3,2, done after the 16th, issued=16.
REQ-031 Down mode, len=3, ready toggling 1,0,0,1,1 -> sel 3, held 2 for two stall cycles, then 1; three transfers, then done.
REQ-032 Fixed mode (FIXED_SEL=2), len=2, with start re-pulsed and mode changed mid-run -> sel=2 for both steps; the mid-run start and mode change have no effect.
REQ-033 rst asserted during the 2nd step of an up run with len=4 -> next cycle all outputs 0, state IDLE, no done pulse.
REQ-034 start together with rst -> stays IDLE, busy=0; start on the next cycle alone -> sel_valid=1 one cycle later.
